// File: rtl/chromakey_pipe_if.sv
// Video-path bundle for chromakey_pipe: foreground/background pixels, syncs,
// frame-shadowed key configuration, composited output and frame statistics.
interface chromakey_pipe_if #(
  parameter int CW    = 4,
  parameter int MW    = 4,
  parameter int CNT_W = 19
);
  logic             de_in;
  logic             hsync_in;
  logic             vsync_in;
  logic             en;
  logic [1:0]       key_sel;
  logic [MW-1:0]    margin;
  logic             blend_en;
  logic [CW-1:0]    fg_r, fg_g, fg_b;
  logic [CW-1:0]    bg_r, bg_g, bg_b;
  logic [CW-1:0]    out_r, out_g, out_b;
  logic             de_out;
  logic             hsync_out;
  logic             vsync_out;
  logic [CNT_W-1:0] key_count;
  logic             key_count_valid;

  modport master (
    output de_in, hsync_in, vsync_in, en, key_sel, margin, blend_en,
           fg_r, fg_g, fg_b, bg_r, bg_g, bg_b,
    input  out_r, out_g, out_b, de_out, hsync_out, vsync_out,
           key_count, key_count_valid
  );

  modport slave (
    input  de_in, hsync_in, vsync_in, en, key_sel, margin, blend_en,
           fg_r, fg_g, fg_b, bg_r, bg_g, bg_b,
    output out_r, out_g, out_b, de_out, hsync_out, vsync_out,
           key_count, key_count_valid
  );
endinterface

// File: rtl/chromakey_pipe.sv
// Three-stage chroma-key compositor: classify, select/blend, output register.
// Key configuration is latched at each vsync rising edge; keyed pixels are counted per frame.
module chromakey_pipe #(
  parameter int CW    = 4,
  parameter int MW    = 4,
  parameter int CNT_W = 19
) (
  input  logic            clk,
  input  logic            reset,
  chromakey_pipe_if.slave bus
);
  // Compare width leaves headroom for channel + margin without wrap-around.
  localparam int SW = ((CW > MW) ? CW : MW) + 2;

  typedef enum logic [1:0] {KEY_GREEN = 2'd0, KEY_BLUE = 2'd1, KEY_BLACK = 2'd2, KEY_NONE = 2'd3} key_sel_e;
  typedef enum logic [1:0] {CLS_PASS, CLS_EDGE, CLS_FULL} cls_e;

  typedef struct packed {
    logic          en;
    key_sel_e      key_sel;
    logic [MW-1:0] margin;
    logic          blend_en;
  } cfg_t;

  typedef struct packed { logic de; logic hsync; logic vsync; } sync_t;
  typedef struct packed { logic [CW-1:0] r; logic [CW-1:0] g; logic [CW-1:0] b; } rgb_t;

  localparam cfg_t CFG_RESET = '{en: 1'b0, key_sel: KEY_NONE, margin: '0, blend_en: 1'b0};

  logic             vsync_d, vsync_rise;
  cfg_t             shadow, s1_cfg;
  sync_t            s1_sync, s2_sync, s3_sync;
  rgb_t             s1_fg, s1_bg, s2_pix, s3_pix, s2_next;
  cls_e             s1_cls;
  logic [SW-1:0]    r_w, g_w, b_w, m_w, h_w;
  logic             inc;
  logic [CNT_W-1:0] acc, key_count_q;
  logic             valid_q;

  function automatic cls_e dominance(input logic [SW-1:0] d, o1, o2, m, h);
    if (d > o1 + m && d > o2 + m) return CLS_FULL;
    if (d > o1 + h && d > o2 + h) return CLS_EDGE;
    return CLS_PASS;
  endfunction

  function automatic logic [CW-1:0] avg(input logic [CW-1:0] a, b);
    logic [CW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CW:1];
  endfunction

  assign vsync_rise = bus.vsync_in & ~vsync_d;

  // NOTE: sequential state uses non-blocking assignments so every stage samples the previous stage's pre-edge value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_d <= 1'b0;
      shadow  <= CFG_RESET;
      s1_cfg  <= CFG_RESET;
      s1_sync <= '0;
      s1_fg   <= '0;
      s1_bg   <= '0;
      s2_sync <= '0;
      s2_pix  <= '0;
      s3_sync <= '0;
      s3_pix  <= '0;
    end else begin
      vsync_d <= bus.vsync_in;
      if (vsync_rise)
        shadow <= '{en: bus.en, key_sel: key_sel_e'(bus.key_sel), margin: bus.margin, blend_en: bus.blend_en};
      // NOTE: the config travels with the pixel, so a pixel presented on the frame-edge cycle still sees the old shadow.
      s1_cfg  <= shadow;
      s1_sync <= '{de: bus.de_in, hsync: bus.hsync_in, vsync: bus.vsync_in};
      s1_fg   <= '{r: bus.fg_r, g: bus.fg_g, b: bus.fg_b};
      s1_bg   <= '{r: bus.bg_r, g: bus.bg_g, b: bus.bg_b};
      s2_sync <= s1_sync;
      s2_pix  <= s2_next;
      s3_sync <= s2_sync;
      s3_pix  <= s2_sync.de ? s2_pix : '0;
    end
  end

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    r_w    = SW'(s1_fg.r);
    g_w    = SW'(s1_fg.g);
    b_w    = SW'(s1_fg.b);
    m_w    = SW'(s1_cfg.margin);
    h_w    = m_w >> 1;
    s1_cls = CLS_PASS;
    if (s1_cfg.en) begin
      case (s1_cfg.key_sel)
        KEY_GREEN: s1_cls = dominance(g_w, r_w, b_w, m_w, h_w);
        KEY_BLUE:  s1_cls = dominance(b_w, r_w, g_w, m_w, h_w);
        KEY_BLACK: begin
          if (r_w <= h_w && g_w <= h_w && b_w <= h_w)      s1_cls = CLS_FULL;
          else if (r_w <= m_w && g_w <= m_w && b_w <= m_w) s1_cls = CLS_EDGE;
        end
        default: s1_cls = CLS_PASS;
      endcase
    end
  end

  always_comb begin
    s2_next = s1_fg;
    if (s1_cls == CLS_FULL)
      s2_next = s1_bg;
    else if (s1_cls == CLS_EDGE && s1_cfg.blend_en)
      s2_next = '{r: avg(s1_fg.r, s1_bg.r), g: avg(s1_fg.g, s1_bg.g), b: avg(s1_fg.b, s1_bg.b)};
  end

  assign inc = s1_sync.de && (s1_cls == CLS_FULL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc         <= '0;
      key_count_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      valid_q <= vsync_rise;
      if (vsync_rise) begin
        key_count_q <= acc;
        acc         <= CNT_W'(inc);
      end else if (inc && acc != '1) begin
        acc <= acc + CNT_W'(1);
      end
    end
  end

  assign bus.out_r           = s3_pix.r;
  assign bus.out_g           = s3_pix.g;
  assign bus.out_b           = s3_pix.b;
  assign bus.de_out          = s3_sync.de;
  assign bus.hsync_out       = s3_sync.hsync;
  assign bus.vsync_out       = s3_sync.vsync;
  assign bus.key_count       = key_count_q;
  assign bus.key_count_valid = valid_q;
endmodule
